pps_conditioner: RTL

//   Cleans the raw external pulse-per-second input before it drives the clock block's pps input.

---
 rtl/pps_conditioner.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pps_conditioner.sv
// PPS input conditioner: synchroniser, debounce, rising-edge detect and
// period checker that qualifies the external second pulse before use.
module pps_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int NOM_PERIOD  = 200,
    parameter int TOL         = 4,
    parameter int LOCK_COUNT  = 3,
    localparam int PW = $clog2(2*NOM_PERIOD+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pps_raw,
    output logic          pps_pulse,
    output logic          pps_valid,
    output logic          pps_lost,
    output logic [PW-1:0] period
);

    localparam int DW = $clog2(DEBOUNCE+1);
    localparam int GW = $clog2(LOCK_COUNT+1);
    localparam logic [PW-1:0] PMAX = PW'(2*NOM_PERIOD);
    localparam logic [PW-1:0] PLO  = PW'(NOM_PERIOD-TOL);
    localparam logic [PW-1:0] PHI  = PW'(NOM_PERIOD+TOL);
    localparam logic [PW-1:0] PTO  = PW'(NOM_PERIOD+TOL+1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [DW-1:0]          db_cnt;
    logic                   filt;
    logic                   filt_d;
    logic                   rise;
    logic [PW-1:0]          per;
    logic [PW-1:0]          p_meas;
    logic                   good;
    logic                   timeout;
    logic [GW-1:0]          good_cnt;
    state_t                 state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pps_raw};
        end
    end

    assign synced = sync[SYNC_STAGES-1];

    // Level flips one cycle after the mismatch run reaches DEBOUNCE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            filt_d <= filt;
            if (db_cnt == DW'(DEBOUNCE)) begin
                filt   <= ~filt;
                db_cnt <= '0;
            end else if (synced != filt) begin
                db_cnt <= db_cnt + DW'(1);
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign rise    = filt & ~filt_d;
    assign p_meas  = per + PW'(1);
    assign good    = rise && (p_meas >= PLO) && (p_meas <= PHI);
    assign timeout = !rise && (p_meas == PTO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per       <= '0;
            period    <= '0;
            good_cnt  <= '0;
            state     <= HUNT;
            pps_pulse <= 1'b0;
            pps_lost  <= 1'b0;
            pps_valid <= 1'b0;
        end else begin
            pps_pulse <= 1'b0;
            pps_lost  <= 1'b0;
            if (rise) begin
                per    <= '0;
                period <= (p_meas > PMAX) ? PMAX : p_meas;
            end else if (per != PMAX) begin
                per <= per + PW'(1);
            end
            unique case (state)
                HUNT: begin
                    if (rise) begin
                        state    <= CHECK;
                        good_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (good) begin
                        good_cnt <= good_cnt + GW'(1);
                        if (good_cnt == GW'(LOCK_COUNT-1)) begin
                            state     <= LOCKED;
                            pps_valid <= 1'b1;
                            pps_pulse <= 1'b1;
                        end
                    end else if (rise) begin
                        good_cnt <= '0;
                    end else if (timeout) begin
                        state <= HUNT;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        pps_pulse <= 1'b1;
                    end else if (rise) begin
                        state     <= CHECK;
                        good_cnt  <= '0;
                        pps_lost  <= 1'b1;
                        pps_valid <= 1'b0;
                    end else if (timeout) begin
                        state     <= HUNT;
                        pps_lost  <= 1'b1;
                        pps_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= HUNT;
                    pps_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
